// File: rtl/guess_pkg.sv
// Shared types and constants for the guess controller and its history buffer.
// Colour helpers wrap within the legal peg range 1..7.
package guess_pkg;

    typedef enum logic [1:0] {
        ST_GUESS   = 2'd0,
        ST_HISTORY = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [2:0]  COLOR_MIN = 3'd1;
    localparam logic [2:0]  COLOR_MAX = 3'd7;
    localparam logic [2:0]  PEG_RESET = 3'b001;
    localparam int unsigned NUM_PEGS  = 4;
    localparam int unsigned PEG_W     = 3;
    localparam int unsigned CODE_W    = 12;

    function automatic logic [2:0] color_next(input logic [2:0] c);
        return (c == COLOR_MAX) ? COLOR_MIN : c + 3'd1;
    endfunction

    function automatic logic [2:0] color_prev(input logic [2:0] c);
        return (c == COLOR_MIN) ? COLOR_MAX : c - 3'd1;
    endfunction

endpackage

// File: rtl/history_buf.sv
// DEPTH x CODE_W register file holding submitted guesses.
// One write port, one combinational read port, synchronous active-low clear.
module history_buf
    import guess_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [CODE_W-1:0] data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CODE_W-1:0] rd_data
);

    logic [CODE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(addr) < DEPTH)) begin
            mem[addr] <= data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < DEPTH) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/guess_controller.sv
// Guess entry, cursor, GUESS/HISTORY/LOCKED mode and history scroll for the peg LED driver.
// Optional HISTORY idle timeout is enabled by defining HIST_TIMEOUT_EN.
module guess_controller
    import guess_pkg::*;
#(
    parameter int unsigned MAX_GUESSES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned CNT_W         = $clog2(MAX_GUESSES + 1),
    localparam int unsigned IDX_W         = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_submit,
    input  logic              btn_mode,
    output logic              blink_enable,
    output logic [1:0]        blink_led,
    output logic [2:0]        guess_rgb0,
    output logic [2:0]        guess_rgb1,
    output logic [2:0]        guess_rgb2,
    output logic [2:0]        guess_rgb3,
    output logic [2:0]        history_rgb0,
    output logic [2:0]        history_rgb1,
    output logic [2:0]        history_rgb2,
    output logic [2:0]        history_rgb3,
    output logic              guess_valid,
    output logic [CODE_W-1:0] guess_code,
    output logic [CNT_W-1:0]  guess_count,
    output logic              game_over
);

    if (MAX_GUESSES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("guess_controller: MAX_GUESSES and TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_q, state_d;
    logic [1:0]         cursor_q, cursor_d;
    logic [PEG_W-1:0]   pegs_q [NUM_PEGS];
    logic [PEG_W-1:0]   pegs_d [NUM_PEGS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d, last_idx;
    logic               valid_q, valid_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  hist_q, hist_d;
    logic               blink_q, over_q;

    logic               we;
    logic [IDX_W-1:0]   wr_addr;
    logic [CODE_W-1:0]  cur_code, rd_data, hist_word;
    logic               up_only, down_only, left_only, right_only;
    logic               any_btn;

`ifdef HIST_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] idle_q, idle_d;
`endif

    assign up_only    = btn_up & ~btn_down;
    assign down_only  = btn_down & ~btn_up;
    assign left_only  = btn_left & ~btn_right;
    assign right_only = btn_right & ~btn_left;
    assign any_btn    = btn_left | btn_right | btn_up | btn_down | btn_submit | btn_mode;
    assign cur_code   = {pegs_q[3], pegs_q[2], pegs_q[1], pegs_q[0]};
    assign wr_addr    = IDX_W'(count_q);
    assign last_idx   = (count_q == '0) ? '0 : IDX_W'(count_q - CNT_W'(1));

    history_buf #(
        .DEPTH   (MAX_GUESSES)
    ) u_history_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .addr    (wr_addr),
        .data    (cur_code),
        .rd_addr (idx_d),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        pegs_d   = pegs_q;
        count_d  = count_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        code_d   = code_q;
        we       = 1'b0;

        unique case (state_q)
            ST_GUESS: begin
                if (btn_mode) begin
                    state_d = ST_HISTORY;
                    idx_d   = last_idx;
                end else if (btn_submit) begin
                    we      = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    valid_d = 1'b1;
                    code_d  = cur_code;
                    idx_d   = wr_addr;
                    if (count_d == CNT_W'(MAX_GUESSES)) begin
                        state_d = ST_LOCKED;
                    end
                end else if (btn_up || btn_down) begin
                    // Simultaneous up+down cancel but still block left/right.
                    if (up_only) begin
                        pegs_d[cursor_q] = color_next(pegs_q[cursor_q]);
                    end else if (down_only) begin
                        pegs_d[cursor_q] = color_prev(pegs_q[cursor_q]);
                    end
                end else if (left_only) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (right_only) begin
                    cursor_d = cursor_q + 2'd1;
                end
            end
            ST_HISTORY, ST_LOCKED: begin
                if (btn_mode && state_q == ST_HISTORY) begin
                    state_d = ST_GUESS;
                end else if (!btn_mode && !btn_submit) begin
                    if (up_only && idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (down_only && idx_q != last_idx) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_GUESS;
        endcase

`ifdef HIST_TIMEOUT_EN
        idle_d = '0;
        if (state_q == ST_HISTORY && !any_btn) begin
            if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_GUESS;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end
`endif

        // Bypass the write so the new entry is visible on the same edge it is stored.
        hist_word = (we && wr_addr == idx_d) ? cur_code : rd_data;
        hist_d    = (count_d == '0) ? '0 : hist_word;
    end

`ifndef HIST_TIMEOUT_EN
    logic unused_any_btn;
    assign unused_any_btn = any_btn;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_GUESS;
            cursor_q <= 2'd0;
            for (int i = 0; i < NUM_PEGS; i++) begin
                pegs_q[i] <= PEG_RESET;
            end
            count_q  <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            hist_q   <= '0;
            blink_q  <= 1'b1;
            over_q   <= 1'b0;
`ifdef HIST_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            pegs_q   <= pegs_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            hist_q   <= hist_d;
            blink_q  <= (state_d == ST_GUESS);
            over_q   <= (state_d == ST_LOCKED);
`ifdef HIST_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign blink_enable = blink_q;
    assign blink_led    = cursor_q;
    assign guess_rgb0   = pegs_q[0];
    assign guess_rgb1   = pegs_q[1];
    assign guess_rgb2   = pegs_q[2];
    assign guess_rgb3   = pegs_q[3];
    assign history_rgb0 = hist_q[2:0];
    assign history_rgb1 = hist_q[5:3];
    assign history_rgb2 = hist_q[8:6];
    assign history_rgb3 = hist_q[11:9];
    assign guess_valid  = valid_q;
    assign guess_code   = code_q;
    assign guess_count  = count_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_guess_controller.sv
// Directed table-driven bench for guess_controller, plus multi-cycle corner sequences.
// The HISTORY timeout sequence runs only when HIST_TIMEOUT_EN is defined.
module tb_guess_controller;

    typedef struct packed {
        logic        be;
        logic [1:0]  led;
        logic [2:0]  g3, g2, g1, g0;
        logic        valid;
        logic [11:0] code;
        logic [3:0]  cnt;
        logic        go;
        logic [2:0]  h3, h2, h1, h0;
    } obs_t;

    typedef struct {
        logic [5:0] btn;
        obs_t       exp;
    } vec_t;

    localparam logic [5:0] B_NONE = 6'b000000;
    localparam logic [5:0] B_MODE = 6'b100000;
    localparam logic [5:0] B_SUB  = 6'b010000;
    localparam logic [5:0] B_UP   = 6'b001000;
    localparam logic [5:0] B_DN   = 6'b000100;
    localparam logic [5:0] B_L    = 6'b000010;
    localparam logic [5:0] B_R    = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_left, btn_right, btn_up, btn_down, btn_submit, btn_mode;
    logic        blink_enable;
    logic [1:0]  blink_led;
    logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic        guess_valid;
    logic [11:0] guess_code;
    logic [3:0]  guess_count;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    guess_controller #(
        .MAX_GUESSES    (8),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_submit   (btn_submit),
        .btn_mode     (btn_mode),
        .blink_enable (blink_enable),
        .blink_led    (blink_led),
        .guess_rgb0   (guess_rgb0),
        .guess_rgb1   (guess_rgb1),
        .guess_rgb2   (guess_rgb2),
        .guess_rgb3   (guess_rgb3),
        .history_rgb0 (history_rgb0),
        .history_rgb1 (history_rgb1),
        .history_rgb2 (history_rgb2),
        .history_rgb3 (history_rgb3),
        .guess_valid  (guess_valid),
        .guess_code   (guess_code),
        .guess_count  (guess_count),
        .game_over    (game_over)
    );

    function automatic obs_t mk(logic be, logic [1:0] led, logic [2:0] g3, logic [2:0] g2,
                                logic [2:0] g1, logic [2:0] g0, logic valid, logic [11:0] code,
                                logic [3:0] cnt, logic go, logic [2:0] h3, logic [2:0] h2,
                                logic [2:0] h1, logic [2:0] h0);
        obs_t o;
        o = '{be, led, g3, g2, g1, g0, valid, code, cnt, go, h3, h2, h1, h0};
        return o;
    endfunction

    function automatic obs_t snap();
        return mk(blink_enable, blink_led, guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0,
                  guess_valid, guess_code, guess_count, game_over,
                  history_rgb3, history_rgb2, history_rgb1, history_rgb0);
    endfunction

    function automatic void add(logic [5:0] b, obs_t e);
        vec_t v;
        v.btn = b;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] b);
        @(negedge clk);
        {btn_mode, btn_submit, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_mode, btn_submit, btn_up, btn_down, btn_left, btn_right} = B_NONE;
    endtask

    task automatic do_reset(input logic [5:0] b);
        @(negedge clk);
        rst_n = 1'b0;
        {btn_mode, btn_submit, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_mode, btn_submit, btn_up, btn_down, btn_left, btn_right} = B_NONE;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {btn_mode, btn_submit, btn_up, btn_down, btn_left, btn_right} = B_NONE;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_obs("reset", snap(), mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Colour wrap, cursor wrap, peg edit to {4,3,2,1}, submit, history view.
        add(B_UP, mk(1, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_L,  mk(1, 3, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_R,  mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_L,  mk(1, 3, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_DN, mk(1, 3, 7, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_DN, mk(1, 3, 6, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_DN, mk(1, 3, 5, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_DN, mk(1, 3, 4, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_L,  mk(1, 2, 4, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 2, 4, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 2, 4, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_L,  mk(1, 1, 4, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_UP, mk(1, 1, 4, 3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_L,  mk(1, 0, 4, 3, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_DN, mk(1, 0, 4, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_DN, mk(1, 0, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(B_SUB,  mk(1, 0, 4, 3, 2, 1, 1, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_NONE, mk(1, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_MODE, mk(0, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_L,    mk(0, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_SUB,  mk(0, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_UP,   mk(0, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_MODE, mk(1, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_UP | B_DN, mk(1, 0, 4, 3, 2, 1, 0, 12'o4321, 1, 0, 4, 3, 2, 1));
        add(B_UP | B_L,  mk(1, 0, 4, 3, 2, 2, 0, 12'o4321, 1, 0, 4, 3, 2, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn);
            chk_obs($sformatf("vec%0d", i), snap(), vecs[i].exp);
        end

        // Three submits, scroll saturation, mode beats submit.
        do_reset(B_NONE);
        step(B_SUB);
        chk("s1_code", int'(guess_code), int'(12'o1111));
        step(B_UP);
        step(B_SUB);
        chk("s2_code", int'(guess_code), int'(12'o1112));
        step(B_UP);
        step(B_SUB);
        chk("s3_count", int'(guess_count), 3);
        step(B_MODE | B_SUB);
        chk("mode_sub_valid", int'(guess_valid), 0);
        chk("mode_sub_be", int'(blink_enable), 0);
        chk("mode_sub_count", int'(guess_count), 3);
        chk("hist_newest", int'(history_rgb0), 3);
        for (int i = 0; i < 5; i++) step(B_UP);
        chk("scroll_oldest", int'(history_rgb0), 1);
        for (int i = 0; i < 5; i++) step(B_DN);
        chk("scroll_newest", int'(history_rgb0), 3);
        step(B_MODE | B_SUB);
        chk("hist_mode_sub_valid", int'(guess_valid), 0);
        chk("hist_mode_sub_be", int'(blink_enable), 1);
        chk("hist_mode_sub_count", int'(guess_count), 3);

        // Reset with a coincident submit suppresses guess_valid.
        do_reset(B_SUB);
        chk("rst_sub_valid", int'(guess_valid), 0);
        chk("rst_sub_count", int'(guess_count), 0);

        // Fill history to lock-out.
        for (int k = 0; k < 8; k++) begin
            step(B_SUB);
            chk($sformatf("fill_valid%0d", k), int'(guess_valid), 1);
            chk($sformatf("fill_count%0d", k), int'(guess_count), k + 1);
            if (k < 7) step(B_UP);
        end
        chk("locked_go", int'(game_over), 1);
        chk("locked_be", int'(blink_enable), 0);
        chk("locked_h0", int'(history_rgb0), 1);
        step(B_SUB);
        chk("locked_sub_valid", int'(guess_valid), 0);
        chk("locked_sub_count", int'(guess_count), 8);
        step(B_MODE);
        chk("locked_mode_go", int'(game_over), 1);
        chk("locked_mode_be", int'(blink_enable), 0);
        step(B_UP);
        chk("locked_scroll_up", int'(history_rgb0), 7);
        step(B_DN);
        chk("locked_scroll_dn", int'(history_rgb0), 1);
        do_reset(B_NONE);
        chk_obs("relock_reset", snap(), mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef HIST_TIMEOUT_EN
        do_reset(B_NONE);
        step(B_MODE);
        chk("to_enter", int'(blink_enable), 0);
        for (int i = 1; i < 10; i++) begin
            step(B_NONE);
            chk($sformatf("to_idle%0d", i), int'(blink_enable), 0);
        end
        step(B_NONE);
        chk("to_expire", int'(blink_enable), 1);
        step(B_MODE);
        for (int i = 0; i < 4; i++) step(B_NONE);
        step(B_UP);
        for (int i = 0; i < 9; i++) begin
            step(B_NONE);
            chk($sformatf("to_restart%0d", i), int'(blink_enable), 0);
        end
        step(B_NONE);
        chk("to_restart_expire", int'(blink_enable), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
